decode_match_stage: RTL and testbench
=====================================

// Module: decode_match_stage
// PURPOSE
//  Registered opcode-match stage in the control path, directly downstream of the instruction register.
//  Accepts a 9-bit instruction field over valid/ready and evaluates a masked 9-input AND match with per-bit bubble inversion.
//  Emits the field plus its match bit over valid/ready to the control sequencer.
//  A 2-entry skid buffer gives full throughput with fully registered outputs. Also keeps a saturating hit counter.
// PARAMETERS
//  BubblesMask  9'h000  bit i=1: input bit i is inverted before the AND (bubble)
//  CareMask     9'h1FF  bit i=0: bit i is forced true (don't-care) in the AND
//  CountWidth   16      width of Hit_Count
// PORTS
//  Clock        in   1           single rising-edge clock
//  Reset_n      in   1           asynchronous, active-low reset
//  In_Valid     in   1           upstream offers In_Field
//  In_Ready     out  1           stage can accept this cycle
//  In_Field     in   9           instruction field
//  Out_Valid    out  1           Out_Field/Out_Match valid
//  Out_Ready    in   1           downstream accepts
//  Out_Field    out  9           buffered field, unmodified
//  Out_Match    out  1           &((Field ^ BubblesMask) | ~CareMask), computed at capture
//  Clear_Count  in   1           synchronous clear of Hit_Count
//  Hit_Count    out  CountWidth  number of matching entries delivered, saturating
// BEHAVIOUR
//  Reset (async assert, sync release): occupancy EMPTY; In_Ready=1, Out_Valid=0, Out_Field=0, Out_Match=0, Hit_Count=0.
//  Accept = In_Valid & In_Ready. Deliver = Out_Valid & Out_Ready. Both are evaluated on the same edge.
//  Match is computed from In_Field in the accept cycle and stored with the entry. Never recomputed at output.
//  Latency: an entry accepted in cycle N is presented on Out_* in cycle N+1 (empty stage).
//  Buffer: main reg M (drives Out_*), skid reg S. States EMPTY, ONE (M full), TWO (M and S full).
//   EMPTY: accept -> ONE (load M).
//   ONE:   accept & deliver -> ONE (reload M). accept only -> TWO (load S).
//          deliver only -> EMPTY. Neither -> ONE.
//   TWO:   deliver -> ONE (M<=S). Accept is impossible in TWO.
//  In_Ready = (state!=TWO), registered. Out_Valid = (state!=EMPTY), registered.
//  Out_Field/Out_Match hold stable while Out_Valid & ~Out_Ready. No drop, duplication or reordering.
//  Out_* are don't-care when Out_Valid=0; they keep their last value.
//  Hit_Count: +1 on Deliver & Out_Match. Stays at all-ones (saturates).
//   Clear_Count has priority: a clear coincident with a hit gives 0.
//  Reset asserted mid-transfer discards all buffered entries immediately. Outputs return to reset values.
// STRUCTURE
//  Shared package decode_pkg: FIELD_W=9; state encoding localparams ST_EMPTY=2'd0, ST_ONE=2'd1, ST_TWO=2'd2.
//  Package also holds function match_fn(field, bubbles, care).
//  One sub-module: skid_buffer2 (generic 2-entry valid/ready buffer, WIDTH=10 here: {match, field}).
//  Top level holds match_fn and the hit counter.
// TESTING
//  1 Reset: Reset_n=0 mid-stream with TWO entries -> In_Ready=1, Out_Valid=0, Hit_Count=0 same cycle (async).
//  2 BubblesMask=9'h005, CareMask=9'h1FF.
//    In_Field=9'h1FA -> Out_Match=1. In_Field=9'h1FF -> Out_Match=0. Hit_Count=1 after both delivered.
//  3 CareMask=9'h00F, In_Field=9'h0AF (bubbles 0) -> Out_Match=1. Upper bits are ignored.
//  4 Out_Ready=0, push 9'h011, 9'h022 -> In_Ready=0 after 2nd accept. Third offer is not accepted.
//    Out_Field holds 9'h011. Release Out_Ready -> 9'h011 then 9'h022, one per cycle.
//  5 Continuous In_Valid=Out_Ready=1, 100 fields -> one delivery per cycle after 1-cycle latency, in order.
//  6 CountWidth=4, 20 matching deliveries -> Hit_Count saturates at 4'hF.
//    Clear_Count with a coincident hit -> Hit_Count=0.

Source files
------------

// File: rtl/decode_pkg.sv
// decode_pkg: shared field width, skid buffer state encoding and the masked match function
package decode_pkg;
  localparam int FIELD_W = 9;
  typedef enum logic [1:0] {ST_EMPTY = 2'd0, ST_ONE = 2'd1, ST_TWO = 2'd2} buf_state_t;
  function automatic logic match_fn(input logic [FIELD_W-1:0] field, input logic [FIELD_W-1:0] bubbles, input logic [FIELD_W-1:0] care);
    return &((field ^ bubbles) | ~care);
  endfunction
endpackage

// File: rtl/skid_buffer2.sv
// skid_buffer2: 2-entry valid/ready buffer with registered ready/valid; main reg drives the output
module skid_buffer2
  import decode_pkg::*;
#(
  parameter int WIDTH = 10
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data
);
  buf_state_t state, state_nx;
  logic [WIDTH-1:0] skid;
  logic acc, dlv;
  assign acc = in_valid & in_ready;
  assign dlv = out_valid & out_ready;
  always_comb begin
    state_nx = state;
    state_nx = state == ST_EMPTY ? (acc ? ST_ONE : ST_EMPTY)
             : state == ST_ONE ? (acc && !dlv ? ST_TWO : (!acc && dlv ? ST_EMPTY : ST_ONE))
             : (dlv ? ST_ONE : ST_TWO);
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_EMPTY;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nx;
      in_ready  <= state_nx != ST_TWO;
      out_valid <= state_nx != ST_EMPTY;
    end
  end
  // accept and deliver only coincide in ONE, where the new entry goes straight to main
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data <= '0;
      skid     <= '0;
    end else begin
      if (acc && (state == ST_EMPTY || dlv)) out_data <= in_data;
      else if (dlv && state == ST_TWO) out_data <= skid;
      if (acc && !dlv && state == ST_ONE) skid <= in_data;
    end
  end
endmodule

// File: rtl/decode_match_stage.sv
// decode_match_stage: registered masked opcode match over valid/ready with a saturating hit counter
module decode_match_stage
  import decode_pkg::*;
#(
  parameter logic [FIELD_W-1:0] BubblesMask = 9'h000,
  parameter logic [FIELD_W-1:0] CareMask    = 9'h1FF,
  parameter int                 CountWidth  = 16
) (
  input  logic                  Clock,
  input  logic                  Reset_n,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic [FIELD_W-1:0]    In_Field,
  output logic                  Out_Valid,
  input  logic                  Out_Ready,
  output logic [FIELD_W-1:0]    Out_Field,
  output logic                  Out_Match,
  input  logic                  Clear_Count,
  output logic [CountWidth-1:0] Hit_Count
);
  logic [FIELD_W:0] in_data, out_data;
  assign in_data = {match_fn(In_Field, BubblesMask, CareMask), In_Field};
  assign {Out_Match, Out_Field} = out_data;
  skid_buffer2 #(.WIDTH(FIELD_W + 1)) u_buf (
    .clk(Clock),
    .rst_n(Reset_n),
    .in_valid(In_Valid),
    .in_ready(In_Ready),
    .in_data(in_data),
    .out_valid(Out_Valid),
    .out_ready(Out_Ready),
    .out_data(out_data)
  );
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) Hit_Count <= '0;
    else if (Clear_Count) Hit_Count <= '0;
    else if (Out_Valid && Out_Ready && Out_Match && !(&Hit_Count)) Hit_Count <= Hit_Count + 1'b1;
  end
endmodule

// File: tb/tb_decode_match_stage.sv
// tb_decode_match_stage: two differently masked instances share stimulus; a negedge monitor scores them against a queue model
module tb_decode_match_stage;
  logic Clock = 0, Reset_n = 0, In_Valid = 0, Out_Ready = 0, Clear_Count = 0;
  logic [8:0] In_Field = 0;
  logic [1:0] ir, ov, om;
  logic [8:0] of0, of1;
  logic [15:0] hc0;
  logic [3:0] hc1;
  int checks = 0, passes = 0, occ = 0, cyc = 0;
  int hit_m [2];
  logic [8:0] q[$];

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc++;

  decode_match_stage #(.BubblesMask(9'h005), .CareMask(9'h1FF), .CountWidth(16)) dut_a (
    .Clock(Clock), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(ir[0]), .In_Field(In_Field),
    .Out_Valid(ov[0]), .Out_Ready(Out_Ready), .Out_Field(of0), .Out_Match(om[0]),
    .Clear_Count(Clear_Count), .Hit_Count(hc0));
  decode_match_stage #(.BubblesMask(9'h000), .CareMask(9'h00F), .CountWidth(4)) dut_b (
    .Clock(Clock), .Reset_n(Reset_n), .In_Valid(In_Valid), .In_Ready(ir[1]), .In_Field(In_Field),
    .Out_Valid(ov[1]), .Out_Ready(Out_Ready), .Out_Field(of1), .Out_Match(om[1]),
    .Clear_Count(Clear_Count), .Hit_Count(hc1));

  task automatic chk(string name, int act, int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // a field matches when every cared-about bit differs from its bubble bit
  function automatic logic exp_match(int d, logic [8:0] f);
    logic [8:0] bub, care;
    logic m;
    bub = d != 0 ? 9'h000 : 9'h005;
    care = d != 0 ? 9'h00F : 9'h1FF;
    m = 1'b1;
    for (int i = 0; i < 9; i++) if (care[i] && f[i] == bub[i]) m = 1'b0;
    return m;
  endfunction

  function automatic int hc(int d);
    return d != 0 ? int'(hc1) : int'(hc0);
  endfunction

  function automatic int hmax(int d);
    return d != 0 ? 15 : 65535;
  endfunction

  always @(negedge Clock) begin
    logic [8:0] f;
    logic got, dlv, acc;
    if (!Reset_n) begin
      q.delete();
      occ = 0;
      hit_m[0] = 0;
      hit_m[1] = 0;
    end else begin
      got = 1'b0;
      f = '0;
      for (int d = 0; d < 2; d++) begin
        chk($sformatf("in_ready_%0d", d), int'(ir[d]), int'(occ < 2));
        chk($sformatf("out_valid_%0d", d), int'(ov[d]), int'(occ > 0));
        chk($sformatf("hit_count_%0d", d), hc(d), hit_m[d]);
      end
      if (ov[0] && Out_Ready) begin
        if (q.size() == 0) begin
          checks++;
          $display("FAIL out_unexpected: delivery of %h with empty scoreboard", of0);
        end else begin
          f = q.pop_front();
          got = 1'b1;
          chk("out_field_0", int'(of0), int'(f));
          chk("out_field_1", int'(of1), int'(f));
          for (int d = 0; d < 2; d++) chk($sformatf("out_match_%0d", d), int'(om[d]), int'(exp_match(d, f)));
        end
      end
      dlv = occ > 0 && Out_Ready;
      acc = In_Valid && occ < 2;
      for (int d = 0; d < 2; d++)
        if (Clear_Count) hit_m[d] = 0;
        else if (dlv && got && exp_match(d, f) && hit_m[d] < hmax(d)) hit_m[d]++;
      occ = occ + int'(acc) - int'(dlv);
    end
  end

  task automatic step();
    @(posedge Clock);
    #1;
  endtask

  task automatic send(logic [8:0] f);
    In_Valid = 1'b1;
    In_Field = f;
    for (int i = 0; i < 50; i++) begin
      @(negedge Clock);
      if (ir[0]) begin
        q.push_back(f);
        step();
        In_Valid = 1'b0;
        return;
      end
      step();
    end
    checks++;
    $display("FAIL accept_timeout: field %h never accepted", f);
    In_Valid = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 20 && occ > 0; i++) step();
  endtask

  initial begin
    int c0;
    repeat (2) step();
    chk("rst_in_ready", int'(ir), 3);
    chk("rst_out_valid", int'(ov), 0);
    chk("rst_out_field", int'(of0), 0);
    chk("rst_out_match", int'(om), 0);
    chk("rst_hit", hc(0) + hc(1), 0);
    Reset_n = 1'b1;
    Out_Ready = 1'b1;
    step();
    send(9'h1FA);
    send(9'h1FF);
    drain();
    chk("hit_after_pair", hc(0), 1);
    send(9'h0AF);
    drain();
    Out_Ready = 1'b0;
    send(9'h011);
    send(9'h022);
    In_Valid = 1'b1;
    In_Field = 9'h033;
    repeat (3) begin
      @(negedge Clock);
      chk("stall_hold_field", int'(of0), 'h011);
      chk("stall_ready", int'(ir[0]), 0);
      step();
    end
    Out_Ready = 1'b1;
    send(9'h033);
    drain();
    c0 = cyc;
    for (int i = 0; i < 100; i++) send(9'($urandom));
    chk("stream_cycles", cyc - c0, 100);
    drain();
    Clear_Count = 1'b1;
    step();
    Clear_Count = 1'b0;
    for (int i = 0; i < 20; i++) send({5'($urandom_range(0, 31)), 4'hF});
    drain();
    chk("saturate_b", hc(1), 15);
    Out_Ready = 1'b0;
    send(9'h0AF);
    Clear_Count = 1'b1;
    Out_Ready = 1'b1;
    step();
    Clear_Count = 1'b0;
    chk("clear_beats_hit", hc(1), 0);
    for (int i = 0; i < 300; i++) begin
      In_Valid = ($urandom % 4) != 0;
      In_Field = ($urandom % 2) != 0 ? {5'($urandom), 4'hF} : (($urandom % 2) != 0 ? 9'h1FA : 9'($urandom));
      Out_Ready = ($urandom % 3) != 0;
      Clear_Count = ($urandom % 40) == 0;
      @(negedge Clock);
      if (In_Valid && ir[0]) q.push_back(In_Field);
      step();
    end
    In_Valid = 1'b0;
    Clear_Count = 1'b0;
    Out_Ready = 1'b1;
    drain();
    Out_Ready = 1'b0;
    send(9'h1FA);
    send(9'h0AF);
    #2;
    Reset_n = 1'b0;
    #1;
    chk("async_in_ready", int'(ir), 3);
    chk("async_out_valid", int'(ov), 0);
    chk("async_out_field", int'(of0), 0);
    chk("async_hit", hc(0) + hc(1), 0);
    step();
    Reset_n = 1'b1;
    Out_Ready = 1'b1;
    repeat (3) step();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
